// File: rtl/decode_stage.sv
// IF/ID pipeline register plus RV32I decoder: captures the fetched word and PC,
// decodes it into opcode_out_t with register indices, immediate and legality flags.
package decode_pkg;
  typedef enum logic [5:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_ECALL, OP_EBREAK
  } opcode_out_t;
endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            stall,
  input  logic            flush,
  output logic            out_valid,
  output opcode_out_t     out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  typedef enum logic [2:0] {IMM_ZERO, IMM_I, IMM_SH, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  opcode_out_t w_op;
  logic        w_ill;
  logic        w_has_rd, w_has_rs1, w_has_rs2;
  imm_fmt_t    w_fmt;
  logic [31:0] w_imm32;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [XLEN-1:0] w_imm;

  assign w_opc = in_instr[6:0];
  assign w_f3  = in_instr[14:12];
  assign w_f7  = in_instr[31:25];

  always_comb begin
    w_op      = OP_NOP;
    w_ill     = 1'b0;
    w_has_rd  = 1'b0;
    w_has_rs1 = 1'b0;
    w_has_rs2 = 1'b0;
    w_fmt     = IMM_ZERO;
    unique case (w_opc)
      7'b0110011: begin
        w_has_rd = 1'b1; w_has_rs1 = 1'b1; w_has_rs2 = 1'b1;
        case ({w_f7, w_f3})
          {7'h00, 3'd0}: w_op = OP_ADD;
          {7'h20, 3'd0}: w_op = OP_SUB;
          {7'h00, 3'd1}: w_op = OP_SLL;
          {7'h00, 3'd2}: w_op = OP_SLT;
          {7'h00, 3'd3}: w_op = OP_SLTU;
          {7'h00, 3'd4}: w_op = OP_XOR;
          {7'h00, 3'd5}: w_op = OP_SRL;
          {7'h20, 3'd5}: w_op = OP_SRA;
          {7'h00, 3'd6}: w_op = OP_OR;
          {7'h00, 3'd7}: w_op = OP_AND;
          default:       w_ill = 1'b1;
        endcase
      end
      7'b0010011: begin
        w_has_rd = 1'b1; w_has_rs1 = 1'b1; w_fmt = IMM_I;
        case (w_f3)
          3'd0: w_op = OP_ADDI;
          3'd2: w_op = OP_SLTI;
          3'd3: w_op = OP_SLTIU;
          3'd4: w_op = OP_XORI;
          3'd6: w_op = OP_ORI;
          3'd7: w_op = OP_ANDI;
          3'd1: begin
            w_fmt = IMM_SH;
            if (w_f7 == 7'h00) w_op = OP_SLLI; else w_ill = 1'b1;
          end
          default: begin
            w_fmt = IMM_SH;
            if (w_f7 == 7'h00)      w_op = OP_SRLI;
            else if (w_f7 == 7'h20) w_op = OP_SRAI;
            else                    w_ill = 1'b1;
          end
        endcase
      end
      7'b0000011: begin
        w_has_rd = 1'b1; w_has_rs1 = 1'b1; w_fmt = IMM_I;
        case (w_f3)
          3'd0:    w_op = OP_LB;
          3'd1:    w_op = OP_LH;
          3'd2:    w_op = OP_LW;
          3'd4:    w_op = OP_LBU;
          3'd5:    w_op = OP_LHU;
          default: w_ill = 1'b1;
        endcase
      end
      7'b0100011: begin
        w_has_rs1 = 1'b1; w_has_rs2 = 1'b1; w_fmt = IMM_S;
        case (w_f3)
          3'd0:    w_op = OP_SB;
          3'd1:    w_op = OP_SH;
          3'd2:    w_op = OP_SW;
          default: w_ill = 1'b1;
        endcase
      end
      7'b1100011: begin
        w_has_rs1 = 1'b1; w_has_rs2 = 1'b1; w_fmt = IMM_B;
        case (w_f3)
          3'd0:    w_op = OP_BEQ;
          3'd1:    w_op = OP_BNE;
          3'd4:    w_op = OP_BLT;
          3'd5:    w_op = OP_BGE;
          3'd6:    w_op = OP_BLTU;
          3'd7:    w_op = OP_BGEU;
          default: w_ill = 1'b1;
        endcase
      end
      7'b1101111: begin w_op = OP_JAL; w_has_rd = 1'b1; w_fmt = IMM_J; end
      7'b1100111: begin
        w_has_rd = 1'b1; w_has_rs1 = 1'b1; w_fmt = IMM_I;
        if (w_f3 == 3'd0) w_op = OP_JALR; else w_ill = 1'b1;
      end
      7'b0110111: begin w_op = OP_LUI;   w_has_rd = 1'b1; w_fmt = IMM_U; end
      7'b0010111: begin w_op = OP_AUIPC; w_has_rd = 1'b1; w_fmt = IMM_U; end
      7'b1110011: begin
        if (in_instr == 32'h0000_0073)      w_op = OP_ECALL;
        else if (in_instr == 32'h0010_0073) w_op = OP_EBREAK;
        else                                w_ill = 1'b1;
      end
      7'b0001111: w_op = OP_NOP;
      default:    w_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_imm32 = '0;
    case (w_fmt)
      IMM_I:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      IMM_SH:  w_imm32 = {27'b0, in_instr[24:20]};
      IMM_S:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      IMM_B:   w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                          in_instr[11:8], 1'b0};
      IMM_U:   w_imm32 = {in_instr[31:12], 12'b0};
      IMM_J:   w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                          in_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // Fields a format lacks are zeroed so downstream hazard checks never see phantom registers.
  assign w_rd  = (w_has_rd  && !w_ill) ? in_instr[11:7]  : '0;
  assign w_rs1 = (w_has_rs1 && !w_ill) ? in_instr[19:15] : '0;
  assign w_rs2 = (w_has_rs2 && !w_ill) ? in_instr[24:20] : '0;
  assign w_imm = w_ill ? '0 : XLEN'($signed(w_imm32));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_opcode  <= OP_NOP;
      out_rd      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_imm     <= '0;
      out_pc      <= RESET_PC;
      out_illegal <= 1'b0;
    end else if (flush || (!stall && !in_valid)) begin
      out_valid   <= 1'b0;
      out_opcode  <= OP_NOP;
      out_rd      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_imm     <= '0;
      out_pc      <= RESET_PC;
      out_illegal <= 1'b0;
    end else if (!stall) begin
      out_valid   <= 1'b1;
      out_opcode  <= w_ill ? OP_NOP : w_op;
      out_rd      <= w_rd;
      out_rs1     <= w_rs1;
      out_rs2     <= w_rs2;
      out_imm     <= w_imm;
      out_pc      <= in_pc;
      out_illegal <= w_ill;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: stimulus pushes expected stage contents into a
// queue, a monitor pops one entry per clock after the capturing edge and compares.
module tb_decode_stage;
  import decode_pkg::*;

  typedef struct {
    string       tag;
    logic        valid;
    opcode_out_t op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, pc;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  opcode_out_t out_opcode;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm, out_pc;
  logic        out_illegal;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        q[$];

  decode_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .stall(stall), .flush(flush), .out_valid(out_valid), .out_opcode(out_opcode),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_pc(out_pc), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic v, opcode_out_t op, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic [31:0] imm, logic [31:0] pc, logic ill);
    exp_t e;
    e.tag = ""; e.valid = v; e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.imm = imm; e.pc = pc; e.ill = ill;
    return e;
  endfunction

  task automatic compare(input exp_t e);
    checks++;
    if (out_valid !== e.valid || out_opcode !== e.op || out_rd !== e.rd || out_rs1 !== e.rs1 ||
        out_rs2 !== e.rs2 || out_imm !== e.imm || out_pc !== e.pc || out_illegal !== e.ill) begin
      errors++;
      $display("FAIL %s: got v=%0b op=%s rd=%0d rs1=%0d rs2=%0d imm=%h pc=%h ill=%0b | exp v=%0b op=%s rd=%0d rs1=%0d rs2=%0d imm=%h pc=%h ill=%0b",
               e.tag, out_valid, out_opcode.name(), out_rd, out_rs1, out_rs2, out_imm, out_pc,
               out_illegal, e.valid, e.op.name(), e.rd, e.rs1, e.rs2, e.imm, e.pc, e.ill);
    end
  endtask

  task automatic drive(input string tag, input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic st, input logic fl, input exp_t e);
    @(negedge clk);
    in_valid = v; in_instr = ins; in_pc = pc; stall = st; flush = fl;
    e.tag = tag;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        compare(e);
      end
    end
  end

  initial begin : stim
    exp_t bub, addi, e;
    int unsigned waited;
    bub  = mk(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    addi = mk(1'b1, OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h200, 1'b0);

    #2;
    e = bub; e.tag = "reset"; compare(e);
    @(negedge clk); rst_n = 1'b1;

    drive("addi", 1, 32'h0050_0093, 32'h100, 0, 0, mk(1, OP_ADDI, 1, 0, 0, 32'd5, 32'h100, 0));
    drive("sub",  1, 32'h4020_81B3, 32'h104, 0, 0, mk(1, OP_SUB, 3, 1, 2, 32'd0, 32'h104, 0));
    drive("lw",   1, 32'h0081_2283, 32'h108, 0, 0, mk(1, OP_LW, 5, 2, 0, 32'd8, 32'h108, 0));
    drive("beq",  1, 32'hFE20_8EE3, 32'h10C, 0, 0, mk(1, OP_BEQ, 0, 1, 2, 32'hFFFF_FFFC, 32'h10C, 0));
    drive("lui",  1, 32'h1234_53B7, 32'h110, 0, 0, mk(1, OP_LUI, 7, 0, 0, 32'h1234_5000, 32'h110, 0));
    drive("jal",  1, 32'h0080_00EF, 32'h114, 0, 0, mk(1, OP_JAL, 1, 0, 0, 32'd8, 32'h114, 0));
    drive("srai", 1, 32'h4030_D093, 32'h118, 0, 0, mk(1, OP_SRAI, 1, 1, 0, 32'd3, 32'h118, 0));
    drive("nop13",1, 32'h0000_0013, 32'h11C, 0, 0, mk(1, OP_ADDI, 0, 0, 0, 32'd0, 32'h11C, 0));
    drive("inv0", 0, 32'h0050_0093, 32'h120, 0, 0, bub);

    drive("cap",  1, 32'h0050_0093, 32'h200, 0, 0, addi);
    for (int i = 0; i < 3; i++)
      drive("stall", 1, 32'h4020_81B3 + i, 32'h300 + 4 * i, 1, 0, addi);
    drive("stflush", 1, 32'h4020_81B3, 32'h304, 1, 1, bub);

    drive("ill_f7",  1, 32'h0200_E0B3, 32'h400, 0, 0, mk(1, OP_NOP, 0, 0, 0, 0, 32'h400, 1));
    drive("ill_hold",1, 32'h0000_0073, 32'h404, 1, 0, mk(1, OP_NOP, 0, 0, 0, 0, 32'h400, 1));
    drive("ecall",   1, 32'h0000_0073, 32'h408, 0, 0, mk(1, OP_ECALL, 0, 0, 0, 0, 32'h408, 0));
    drive("ill_zero",1, 32'h0000_0000, 32'h40C, 0, 0, mk(1, OP_NOP, 0, 0, 0, 0, 32'h40C, 1));
    drive("ill_ld",  1, 32'h0000_3083, 32'h410, 0, 0, mk(1, OP_NOP, 0, 0, 0, 0, 32'h410, 1));
    drive("fence",   1, 32'h0FF0_000F, 32'h414, 0, 0, mk(1, OP_NOP, 0, 0, 0, 0, 32'h414, 0));
    drive("ill_flush",1, 32'h0000_0000, 32'h418, 0, 1, bub);
    drive("addi2",   1, 32'h0050_0093, 32'h200, 0, 0, addi);

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    in_valid = 1'b1; in_instr = 32'h4020_81B3; in_pc = 32'h500; stall = 1'b1; flush = 1'b0;
    #1;
    e = bub; e.tag = "async_rst"; compare(e);
    @(negedge clk); rst_n = 1'b1;
    drive("rst_stall", 1, 32'h4020_81B3, 32'h500, 1, 0, bub);
    drive("resume", 1, 32'h4020_81B3, 32'h500, 0, 0, mk(1, OP_SUB, 3, 1, 2, 0, 32'h500, 0));
    drive("idle", 0, 32'h0, 32'h0, 0, 0, bub);

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Upstream neighbour of the control unit: the IF/ID pipeline register plus the instruction decoder.
- Captures the fetched instruction and PC, then decodes the 32-bit RV32I word into the opcode_out_t enum that the control unit consumes.
- Also produces register indices, the sign-extended immediate, and valid/illegal flags.
- Honours hazard-unit stall and branch/jump flush.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, value of out_pc after reset or flush.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  fetch presents a valid instruction this cycle.
- in_instr  input  32  fetched instruction word.
- in_pc  input  XLEN  PC of in_instr.
- stall  input  1  hold current stage contents (load-use hazard).
- flush  input  1  squash stage contents (taken branch/jump).
- out_valid  output  1  stage holds a live instruction.
- out_opcode  output  opcode_out_t  decoded instruction enum, fed to the control unit.
- out_rd  output  5  destination register index.
- out_rs1  output  5  source register 1 index.
- out_rs2  output  5  source register 2 index.
- out_imm  output  XLEN  sign-extended immediate.
- out_pc  output  XLEN  PC of the decoded instruction.
- out_illegal  output  1  in_valid was high but the encoding is unrecognised.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_opcode=NOP, out_illegal=0.
  - out_rd, out_rs1, out_rs2, out_imm all 0.
  - out_pc=RESET_PC.
- Latency: decode is combinational on in_instr; all outputs are registered, so an instruction appears on the outputs 1 cycle after capture.
- Per rising edge, priority flush > stall > capture:
  - flush=1: load the bubble (same values as reset). Applies even if stall=1 in the same cycle.
  - stall=1, flush=0: every output holds its value.
  - Otherwise:
    - out_valid <= in_valid.
    - If in_valid=0, load the bubble.
    - If in_valid=1, load the decoded fields and out_pc <= in_pc.
- Register fields:
  - out_rd=instr[11:7], out_rs1=instr[19:15], out_rs2=instr[24:20].
  - Forced to 0 for formats that lack the field: U/J have no rs1/rs2; S/B have no rd; I has no rs2.
  - This prevents false hazards downstream.
- Opcode map, keyed on instr[6:0], funct3, funct7:
  - 0110011 R-type: ADD/SUB (funct7 0x00/0x20), SLL, SLT, SLTU, XOR, SRL/SRA (funct7 0x00/0x20), OR, AND. Any other funct7 is illegal.
  - 0010011 I-ALU: ADDI, SLTI, SLTIU, XORI, ORI, ANDI. SLLI requires funct7=0x00. SRLI/SRAI require funct7=0x00/0x20.
  - 0000011 loads: LB, LH, LW, LBU, LHU (funct3 0,1,2,4,5). Other funct3 values are illegal.
  - 0100011 stores: SB, SH, SW (funct3 0,1,2).
  - 1100011 branches: BEQ, BNE, BLT, BGE, BLTU, BGEU (funct3 0,1,4,5,6,7).
  - 1101111 JAL.
  - 1100111 JALR (funct3=0).
  - 0110111 LUI.
  - 0010111 AUIPC.
  - 1110011: ECALL (instr=0x00000073), EBREAK (0x00100073). Other SYSTEM encodings are illegal.
  - 0001111 FENCE: decodes to NOP, valid=1, not illegal.
- Immediates, all sign-extended from instr[31]:
  - I-type: instr[31:20].
  - Shift immediates: imm = {27'b0, instr[24:20]}.
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type: {instr[31:12], 12'b0}.
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R-type and SYSTEM: imm=0.
- Illegal encodings:
  - out_opcode=NOP, out_illegal=1, out_valid=1, rd/rs1/rs2/imm=0.
  - The illegal flag stays with the instruction: it is held on stall and cleared by flush.
- Instruction 0x00000000 is illegal. Canonical NOP 0x00000013 decodes as ADDI x0,x0,0.
- Reset deasserted mid-stall: the stage resumes from the bubble. No stale state survives reset.

Test Plan:
- Reset, then in_instr=0x00500093, in_pc=0x100, in_valid=1 → next cycle: out_opcode=ADDI, rd=1, rs1=0, imm=5, pc=0x100, valid=1.
- 0x402081B3 → SUB, rd=3, rs1=1, rs2=2, imm=0. Then 0x00812283 → LW, rd=5, rs1=2, rs2=0, imm=8.
- 0xFE208EE3 → BEQ, rs1=1, rs2=2, rd=0, imm=0xFFFFFFFC. Then 0x123453B7 → LUI, rd=7, imm=0x12345000.
- Capture ADDI, assert stall 3 cycles while in_instr changes → outputs unchanged. Assert stall+flush together → next cycle valid=0, opcode=NOP, pc=RESET_PC.
- in_instr=0x0200E0B3 (funct7 0x01) → illegal=1, opcode=NOP, valid=1. in_instr=0x00000073 → ECALL, illegal=0.
- Drop rst_n asynchronously mid-cycle while valid=1 → outputs reach reset values immediately, before the next clock edge.
